// File: rtl/sobel_pkg.sv
// Shared widths, types and window packing for the Sobel front end.
// Pixel, row and coordinate types are fixed here for every stage.
package sobel_pkg;

  localparam int PIX_W   = 8;
  localparam int WIN_W   = 3 * PIX_W;
  localparam int COORD_W = 8;

  typedef logic [PIX_W-1:0]   pix_t;
  typedef logic [WIN_W-1:0]   linha_t;
  typedef logic [COORD_W-1:0] coord_t;

  // One vertical slice of the window, top = oldest line.
  typedef struct packed {
    pix_t top;
    pix_t mid;
    pix_t bot;
  } coluna_t;

  function automatic linha_t pack_row(
    input pix_t esq,
    input pix_t cen,
    input pix_t dir
  );
    return {esq, cen, dir};
  endfunction

endpackage

// File: rtl/gerador_janela_if.sv
// Pixel-in / window-out handshake bundle.
// master = source+consumer side, slave = window generator.
interface gerador_janela_if;
  import sobel_pkg::*;

  pix_t   pix_in;
  logic   pix_valid;
  logic   pix_ready;
  linha_t linha1;
  linha_t linha2;
  linha_t linha3;
  logic   win_valid;
  logic   win_ready;
  coord_t win_col;
  coord_t win_row;
  logic   frame_done;

  modport master (
    output pix_in,
    output pix_valid,
    output win_ready,
    input  pix_ready,
    input  linha1,
    input  linha2,
    input  linha3,
    input  win_valid,
    input  win_col,
    input  win_row,
    input  frame_done
  );

  modport slave (
    input  pix_in,
    input  pix_valid,
    input  win_ready,
    output pix_ready,
    output linha1,
    output linha2,
    output linha3,
    output win_valid,
    output win_col,
    output win_row,
    output frame_done
  );

endinterface

// File: rtl/linha_buffer.sv
// One image line of delay: synchronous-read RAM, read-before-write.
// Contents are never cleared; the window gating hides stale data.
module linha_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    rdata_q <= mem[raddr];
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/gerador_janela.sv
// Raster pixel stream to 3x3 windows for the Sobel datapath.
// Two line buffers, a 2-column shift window and one output register.
module gerador_janela
  import sobel_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input logic             clk,
  input logic             rst,
  gerador_janela_if.slave bus
);

  localparam int     AW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam coord_t LAST_C = coord_t'(IMG_W - 1);
  localparam coord_t LAST_R = coord_t'(IMG_H - 1);
  localparam coord_t DOIS   = coord_t'(2);

  coord_t  col_q, col_d;
  coord_t  row_q, row_d;
  coluna_t c0_q, c0_d;
  coluna_t c1_q, c1_d;
  coluna_t nova;

  linha_t  l1_q, l1_d;
  linha_t  l2_q, l2_d;
  linha_t  l3_q, l3_d;
  coord_t  wc_q, wc_d;
  coord_t  wr_q, wr_d;
  logic    vld_q, vld_d;
  logic    fd_q, fd_d;

  pix_t    lb0_rd;
  pix_t    lb1_rd;
  logic    pronto;
  logic    accept;

  assign pronto = !vld_q || bus.win_ready;
  assign accept = bus.pix_valid && pronto;

  // Read address runs one step ahead so column c is ready when its pixel lands.
  linha_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W),
    .AW    (AW)
  ) linebuf0 (
    .clk   (clk),
    .we    (accept),
    .waddr (col_q[AW-1:0]),
    .wdata (bus.pix_in),
    .raddr (col_d[AW-1:0]),
    .rdata (lb0_rd)
  );

  linha_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W),
    .AW    (AW)
  ) linebuf1 (
    .clk   (clk),
    .we    (accept),
    .waddr (col_q[AW-1:0]),
    .wdata (lb0_rd),
    .raddr (col_d[AW-1:0]),
    .rdata (lb1_rd)
  );

  always_comb begin
    nova  = '{top: lb1_rd, mid: lb0_rd, bot: bus.pix_in};
    col_d = col_q;
    row_d = row_q;
    c0_d  = c0_q;
    c1_d  = c1_q;
    l1_d  = l1_q;
    l2_d  = l2_q;
    l3_d  = l3_q;
    wc_d  = wc_q;
    wr_d  = wr_q;
    vld_d = vld_q;
    fd_d  = fd_q;

    if (rst) begin
      col_d = '0;
    end else if (accept) begin
      c0_d = c1_q;
      c1_d = nova;
      if (col_q == LAST_C) begin
        col_d = '0;
        row_d = (row_q == LAST_R) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    if (!rst && accept && row_q >= DOIS && col_q >= DOIS) begin
      vld_d = 1'b1;
      l1_d  = pack_row(c0_q.top, c1_q.top, nova.top);
      l2_d  = pack_row(c0_q.mid, c1_q.mid, nova.mid);
      l3_d  = pack_row(c0_q.bot, c1_q.bot, nova.bot);
      wc_d  = col_q - DOIS;
      wr_d  = row_q - DOIS;
      fd_d  = (row_q == LAST_R) && (col_q == LAST_C);
    end else if (bus.win_ready) begin
      vld_d = 1'b0;
      fd_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      c0_q  <= '0;
      c1_q  <= '0;
      l1_q  <= '0;
      l2_q  <= '0;
      l3_q  <= '0;
      wc_q  <= '0;
      wr_q  <= '0;
      vld_q <= 1'b0;
      fd_q  <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      c0_q  <= c0_d;
      c1_q  <= c1_d;
      l1_q  <= l1_d;
      l2_q  <= l2_d;
      l3_q  <= l3_d;
      wc_q  <= wc_d;
      wr_q  <= wr_d;
      vld_q <= vld_d;
      fd_q  <= fd_d;
    end
  end

  assign bus.pix_ready  = pronto;
  assign bus.linha1     = l1_q;
  assign bus.linha2     = l2_q;
  assign bus.linha3     = l3_q;
  assign bus.win_valid  = vld_q;
  assign bus.win_col    = wc_q;
  assign bus.win_row    = wr_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_gerador_janela.sv
// Bench for gerador_janela: 4x4 directed scenarios and a 7x5 random run,
// each compared against windows computed straight from the image.
module tb_gerador_janela;

  typedef struct packed {
    logic [23:0] l1;
    logic [23:0] l2;
    logic [23:0] l3;
    logic [7:0]  col;
    logic [7:0]  row;
    logic        fd;
  } win_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gerador_janela_if if4 ();
  gerador_janela_if if7 ();

  gerador_janela #(.IMG_W(4), .IMG_H(4)) u4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.slave)
  );

  gerador_janela #(.IMG_W(7), .IMG_H(5)) u7 (
    .clk (clk),
    .rst (rst),
    .bus (if7.slave)
  );

  win_t got4[$];
  win_t got7[$];

  always @(negedge clk) begin
    if (if4.win_valid === 1'b1 && if4.win_ready === 1'b1)
      got4.push_back({if4.linha1, if4.linha2, if4.linha3,
                      if4.win_col, if4.win_row, if4.frame_done});
    if (if7.win_valid === 1'b1 && if7.win_ready === 1'b1)
      got7.push_back({if7.linha1, if7.linha2, if7.linha3,
                      if7.win_col, if7.win_row, if7.frame_done});
  end

  // Every interior window of one frame, straight from the pixel array.
  task automatic model(input int w, input int h,
                       input logic [7:0] px[$], output win_t q[$]);
    q = {};
    for (int r = 2; r < h; r++) begin
      for (int c = 2; c < w; c++) begin
        win_t e;
        e.l1  = {px[(r-2)*w+c-2], px[(r-2)*w+c-1], px[(r-2)*w+c]};
        e.l2  = {px[(r-1)*w+c-2], px[(r-1)*w+c-1], px[(r-1)*w+c]};
        e.l3  = {px[r*w+c-2], px[r*w+c-1], px[r*w+c]};
        e.col = 8'(c - 2);
        e.row = 8'(r - 2);
        e.fd  = (r == h - 1) && (c == w - 1);
        q.push_back(e);
      end
    end
  endtask

  function automatic void ramp4(input logic [7:0] base, output logic [7:0] px[$]);
    px = {};
    for (int i = 0; i < 16; i++) px.push_back(8'(base + 8'(i)));
  endfunction

  task automatic send4(input logic [7:0] px[$], input bit gaps);
    for (int i = 0; i < px.size(); i++) begin
      int  n;
      bit  acc;
      n = gaps ? $urandom_range(0, 2) : 0;
      if (n > 0) begin
        if4.pix_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
      end
      if4.pix_in    = px[i];
      if4.pix_valid = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc) begin
        @(negedge clk);
        acc = if4.pix_ready;
        @(posedge clk); #1;
        n++;
        if (!acc && n > 1000) begin
          checks++; errors++;
          $display("FAIL send4_timeout pixel %0d not accepted, pix_ready=%b want 1",
                   i, if4.pix_ready);
          if4.pix_valid = 1'b0;
          return;
        end
      end
    end
    if4.pix_valid = 1'b0;
  endtask

  task automatic send7(input logic [7:0] px[$]);
    for (int i = 0; i < px.size(); i++) begin
      int  n;
      bit  acc;
      n = $urandom_range(0, 2);
      if (n > 0) begin
        if7.pix_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
      end
      if7.pix_in    = px[i];
      if7.pix_valid = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc) begin
        @(negedge clk);
        acc = if7.pix_ready;
        @(posedge clk); #1;
        n++;
        if (!acc && n > 1000) begin
          checks++; errors++;
          $display("FAIL send7_timeout pixel %0d not accepted, pix_ready=%b want 1",
                   i, if7.pix_ready);
          if7.pix_valid = 1'b0;
          return;
        end
      end
    end
    if7.pix_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if4.pix_valid = 1'b0; if4.win_ready = 1'b1; if4.pix_in = '0;
    if7.pix_valid = 1'b0; if7.win_ready = 1'b1; if7.pix_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (if4.win_valid !== 1'b0) begin
      errors++; $display("FAIL reset_win_valid got %b want 0", if4.win_valid);
    end
    checks++;
    if (if4.frame_done !== 1'b0) begin
      errors++; $display("FAIL reset_frame_done got %b want 0", if4.frame_done);
    end
    checks++;
    if ({if4.linha1, if4.linha2, if4.linha3} !== 72'h0) begin
      errors++; $display("FAIL reset_linhas got %h want 0",
                         {if4.linha1, if4.linha2, if4.linha3});
    end
    checks++;
    if ({if4.win_col, if4.win_row} !== 16'h0) begin
      errors++; $display("FAIL reset_coords got %h want 0", {if4.win_col, if4.win_row});
    end
    checks++;
    if (if4.pix_ready !== 1'b1 || if7.pix_ready !== 1'b1) begin
      errors++; $display("FAIL reset_pix_ready got %b/%b want 1/1",
                         if4.pix_ready, if7.pix_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_clean();
    logic [7:0] px[$];
    win_t exp[$];
    ramp4(8'h00, px);
    model(4, 4, px, exp);
    got4 = {};
    send4(px, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (got4.size() != 4) begin
      errors++; $display("FAIL clean_count got %0d want 4", got4.size());
    end
    for (int i = 0; i < exp.size() && i < got4.size(); i++) begin
      checks++;
      if (got4[i] !== exp[i]) begin
        errors++;
        $display("FAIL clean_win%0d got %h/%h/%h c%0d r%0d f%b want %h/%h/%h c%0d r%0d f%b",
                 i, got4[i].l1, got4[i].l2, got4[i].l3, got4[i].col, got4[i].row, got4[i].fd,
                 exp[i].l1, exp[i].l2, exp[i].l3, exp[i].col, exp[i].row, exp[i].fd);
      end
    end
    if (got4.size() == 4) begin
      checks++;
      if (got4[0].l1 !== 24'h000102 || got4[0].l3 !== 24'h08090A) begin
        errors++; $display("FAIL clean_first got %h/%h want 000102/08090a",
                           got4[0].l1, got4[0].l3);
      end
      checks++;
      if (got4[1].l2 !== 24'h050607 || got4[1].col !== 8'd1) begin
        errors++; $display("FAIL clean_second got %h c%0d want 050607 c1",
                           got4[1].l2, got4[1].col);
      end
      checks++;
      if (got4[3].l3 !== 24'h0D0E0F || !got4[3].fd || got4[2].fd) begin
        errors++; $display("FAIL clean_last got %h f%b prev f%b want 0d0e0f f1 prev f0",
                           got4[3].l3, got4[3].fd, got4[2].fd);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] px[$];
    win_t exp[$];
    win_t snap;
    int   n;
    ramp4(8'h00, px);
    model(4, 4, px, exp);
    got4 = {};
    if4.win_ready = 1'b0;
    fork
      send4(px, 1'b0);
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (if4.win_valid !== 1'b1 && n < 200);
        checks++;
        if (if4.win_valid !== 1'b1) begin
          errors++; $display("FAIL bp_first_timeout got %b want 1", if4.win_valid);
        end
        snap = {if4.linha1, if4.linha2, if4.linha3, if4.win_col, if4.win_row, if4.frame_done};
        checks++;
        if (snap !== exp[0]) begin
          errors++; $display("FAIL bp_first got %h want %h", snap, exp[0]);
        end
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          checks++;
          if (if4.pix_ready !== 1'b0 || if4.win_valid !== 1'b1 ||
              {if4.linha1, if4.linha2, if4.linha3, if4.win_col, if4.win_row,
               if4.frame_done} !== snap) begin
            errors++;
            $display("FAIL bp_hold%0d got rdy=%b vld=%b %h want rdy=0 vld=1 %h", k,
                     if4.pix_ready, if4.win_valid,
                     {if4.linha1, if4.linha2, if4.linha3}, {snap.l1, snap.l2, snap.l3});
          end
        end
        @(posedge clk); #1;
        if4.win_ready = 1'b1;
      end
    join
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (got4.size() != exp.size()) begin
      errors++; $display("FAIL bp_count got %0d want %0d", got4.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got4.size(); i++) begin
      checks++;
      if (got4[i] !== exp[i]) begin
        errors++; $display("FAIL bp_win%0d got %h want %h", i, got4[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] junk[$];
    logic [7:0] px[$];
    win_t exp[$];
    junk = {};
    for (int i = 0; i < 6; i++) junk.push_back(8'($urandom_range(0, 255)));
    got4 = {};
    send4(junk, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (got4.size() != 0) begin
      errors++; $display("FAIL rst_mid_early got %0d windows want 0", got4.size());
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ramp4(8'h00, px);
    model(4, 4, px, exp);
    send4(px, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (got4.size() != exp.size()) begin
      errors++; $display("FAIL rst_mid_count got %0d want %0d", got4.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got4.size(); i++) begin
      checks++;
      if (got4[i] !== exp[i]) begin
        errors++; $display("FAIL rst_mid_win%0d got %h want %h", i, got4[i], exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] f1[$];
    logic [7:0] f2[$];
    win_t e1[$];
    win_t e2[$];
    win_t exp[$];
    int   nfd;
    ramp4(8'h00, f1);
    ramp4(8'h40, f2);
    model(4, 4, f1, e1);
    model(4, 4, f2, e2);
    exp = {e1, e2};
    got4 = {};
    send4({f1, f2}, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (got4.size() != 8) begin
      errors++; $display("FAIL b2b_count got %0d want 8", got4.size());
    end
    nfd = 0;
    foreach (got4[i]) if (got4[i].fd) nfd++;
    checks++;
    if (nfd != 2) begin
      errors++; $display("FAIL b2b_frame_done got %0d want 2", nfd);
    end
    for (int i = 0; i < exp.size() && i < got4.size(); i++) begin
      checks++;
      if (got4[i] !== exp[i]) begin
        errors++; $display("FAIL b2b_win%0d got %h want %h", i, got4[i], exp[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] px[$];
    win_t exp[$];
    bit   done;
    px = {};
    for (int i = 0; i < 35; i++) px.push_back(8'($urandom_range(0, 255)));
    model(7, 5, px, exp);
    got7 = {};
    done = 1'b0;
    fork
      begin
        send7(px);
        done = 1'b1;
      end
      begin
        while (!done) begin
          if7.win_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        if7.win_ready = 1'b1;
      end
    join
    repeat (6) begin @(posedge clk); #1; end
    checks++;
    if (got7.size() != 15) begin
      errors++; $display("FAIL rand_count got %0d want 15", got7.size());
    end
    for (int i = 0; i < exp.size() && i < got7.size(); i++) begin
      checks++;
      if (got7[i] !== exp[i]) begin
        errors++; $display("FAIL rand_win%0d got %h want %h", i, got7[i], exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_backpressure();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
